// File: rtl/mips_cpu_mem_access_unit_pkg.sv
// Shared types and lane helpers for the load/store bus bridge.
// Op encodings match the CPU load/store stage.
package mips_cpu_mem_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'd0,
      OP_LBU = 3'd1,
      OP_LH  = 3'd2,
      OP_LHU = 3'd3,
      OP_LW  = 3'd4,
      OP_SB  = 3'd5,
      OP_SH  = 3'd6,
      OP_SW  = 3'd7
   } mem_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic is_store(mem_op_t op);
      return op inside {OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic logic is_aligned(mem_op_t op, logic [1:0] off);
      logic ok;
      unique case (op)
         OP_LH, OP_LHU, OP_SH: ok = ~off[0];
         OP_LW, OP_SW:         ok = (off == 2'b00);
         default:              ok = 1'b1;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] byteenable_for(mem_op_t op, logic [1:0] off);
      logic [3:0] be;
      unique case (op)
         OP_LB, OP_LBU, OP_SB: be = 4'b0001 << off;
         OP_LH, OP_LHU, OP_SH: be = off[1] ? 4'b1100 : 4'b0011;
         default:              be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] writedata_for(mem_op_t op, logic [31:0] wd);
      logic [31:0] d;
      unique case (op)
         OP_SB:   d = {4{wd[7:0]}};
         OP_SH:   d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mips_cpu_mem_access_unit_if.sv
// CPU-side request/response bundle and Avalon-MM master bundle.
// master = initiator of the transfer, slave = responder.
interface mips_cpu_mem_req_if;
   import mips_cpu_mem_pkg::*;

   logic        req_valid;
   logic        req_ready;
   mem_op_t     req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

interface mips_cpu_avm_if;
   logic [31:0] avm_address;
   logic [3:0]  avm_byteenable;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;

   modport master (
      output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
      input  avm_waitrequest, avm_readdata
   );

   modport slave (
      input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
      output avm_waitrequest, avm_readdata
   );
endinterface

// File: rtl/mips_cpu_mem_access_unit_load_extract.sv
// Picks the addressed lane out of a read word and extends it.
// Store ops yield zero so the response bus stays clean.
module mips_cpu_load_extract
   import mips_cpu_mem_pkg::*;
(
   input  mem_op_t     op,
   input  logic [1:0]  offset,
   input  logic [31:0] readdata,
   output logic [31:0] resp_rdata
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b          = readdata[{offset, 3'b000} +: 8];
      h          = offset[1] ? readdata[31:16] : readdata[15:0];
      resp_rdata = '0;
      unique case (op)
         OP_LB:   resp_rdata = {{24{b[7]}}, b};
         OP_LBU:  resp_rdata = {24'h0, b};
         OP_LH:   resp_rdata = {{16{h[15]}}, h};
         OP_LHU:  resp_rdata = {16'h0, h};
         OP_LW:   resp_rdata = readdata;
         default: resp_rdata = '0;
      endcase
   end

endmodule

// File: rtl/mips_cpu_mem_access_unit.sv
// Single-outstanding Avalon-MM master for CPU byte/half/word loads and stores.
// All outputs are registered; misaligned requests never reach the bus.
module mips_cpu_mem_access_unit
   import mips_cpu_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic               clk,
   input logic               reset_n,
   mips_cpu_mem_req_if.slave req,
   mips_cpu_avm_if.master    avm
);

   localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

   state_t      state_q, state_d;
   mem_op_t     op_q, op_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] cnt_q, cnt_d;
   logic        ready_q, ready_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rerr_q, rerr_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [31:0] ext_data;

   mips_cpu_load_extract u_extract (
      .op         (op_q),
      .offset     (off_q),
      .readdata   (avm.avm_readdata),
      .resp_rdata (ext_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         op_q     <= OP_LB;
         off_q    <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rerr_q   <= 1'b0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         off_q    <= off_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rerr_q   <= rerr_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      off_d    = off_q;
      cnt_d    = cnt_q;
      ready_d  = ready_q;
      rvalid_d = 1'b0;
      rdata_d  = '0;
      rerr_d   = 1'b0;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      unique case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            if (req.req_valid) begin
               op_d    = req.req_op;
               off_d   = req.req_addr[1:0];
               ready_d = 1'b0;
               if (is_aligned(req.req_op, req.req_addr[1:0])) begin
                  state_d = S_BUS;
                  addr_d  = {req.req_addr[31:2], 2'b00};
                  be_d    = byteenable_for(req.req_op, req.req_addr[1:0]);
                  wdata_d = writedata_for(req.req_op, req.req_wdata);
                  rd_d    = ~is_store(req.req_op);
                  wr_d    = is_store(req.req_op);
                  cnt_d   = '0;
               end else begin
                  state_d  = S_DONE;
                  rvalid_d = 1'b1;
                  rerr_d   = 1'b1;
               end
            end
         end
         S_BUS: begin
            if (!avm.avm_waitrequest) begin
               state_d  = S_DONE;
               rd_d     = 1'b0;
               wr_d     = 1'b0;
               rvalid_d = 1'b1;
               rdata_d  = ext_data;
            end else if (TO_EN && cnt_q == TO_LAST) begin
               // Give up on a stuck slave; the strobe drops with the error.
               state_d  = S_DONE;
               rd_d     = 1'b0;
               wr_d     = 1'b0;
               rvalid_d = 1'b1;
               rerr_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
         end
      endcase
   end

   assign req.req_ready      = ready_q;
   assign req.resp_valid     = rvalid_q;
   assign req.resp_rdata     = rdata_q;
   assign req.resp_error     = rerr_q;
   assign avm.avm_address    = addr_q;
   assign avm.avm_byteenable = be_q;
   assign avm.avm_writedata  = wdata_q;
   assign avm.avm_read       = rd_q;
   assign avm.avm_write      = wr_q;

endmodule

// File: tb/tb_mips_cpu_mem_access_unit.sv
// Scoreboard bench for the load/store bus bridge with a wait-state slave model.
// Responses are checked by a monitor independent of the stimulus thread.
module tb_mips_cpu_mem_access_unit;
   import mips_cpu_mem_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mips_cpu_mem_req_if req ();
   mips_cpu_avm_if     avm ();

   mips_cpu_mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk     (clk),
      .reset_n (rst_n),
      .req     (req.slave),
      .avm     (avm.master)
   );

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   exp_t sbq[$];

   int          waits = 0;
   logic [31:0] rd_val = '0;
   int          busy = 0;

   int          strb_n;
   logic        saw_rd, saw_wr, both_hi, unstable;
   logic [31:0] s_addr, s_wd;
   logic [3:0]  s_be;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave: stall for 'waits' cycles of each strobe, then complete.
   always @(negedge clk) begin
      avm.avm_readdata = rd_val;
      if (avm.avm_read || avm.avm_write) begin
         avm.avm_waitrequest = (busy < waits);
         busy++;
      end else begin
         busy = 0;
         avm.avm_waitrequest = 1'b1;
      end
   end

   // Bus observer: strobe length and stability of the held fields.
   always @(negedge clk) begin
      if (avm.avm_read || avm.avm_write) begin
         if (strb_n > 0 && (avm.avm_address != s_addr ||
             avm.avm_byteenable != s_be || avm.avm_writedata != s_wd))
            unstable = 1'b1;
         if (avm.avm_read && avm.avm_write) both_hi = 1'b1;
         saw_rd = saw_rd | avm.avm_read;
         saw_wr = saw_wr | avm.avm_write;
         s_addr = avm.avm_address;
         s_be   = avm.avm_byteenable;
         s_wd   = avm.avm_writedata;
         strb_n++;
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      if (req.resp_valid) begin
         n_cmp++;
         if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_resp: got rdata=%h err=%0b at cyc %0d, required none",
                     req.resp_rdata, req.resp_error, cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            if (req.resp_rdata !== e.rdata || req.resp_error !== e.err || cyc != e.cyc) begin
               n_err++;
               $display("FAIL resp: got rdata=%h err=%0b cyc=%0d, required rdata=%h err=%0b cyc=%0d",
                        req.resp_rdata, req.resp_error, cyc, e.rdata, e.err, e.cyc);
            end
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req.req_ready) return;
      end
      n_cmp++;
      n_err++;
      $display("FAIL wait_ready: got ready=0, required 1 within 20 cycles");
   endtask

   task automatic drive_accept(mem_op_t op, logic [31:0] a, logic [31:0] wd);
      req.req_valid = 1'b1;
      req.req_op    = op;
      req.req_addr  = a;
      req.req_wdata = wd;
      @(posedge clk);
      #1;
      req.req_valid = 1'b0;
      req.req_op    = OP_SW;
      req.req_addr  = 32'hFFFF_FFFF;
      req.req_wdata = 32'h5A5A_0F0F;
   endtask

   task automatic do_req(string nm, mem_op_t op, logic [31:0] a, logic [31:0] wd,
                         int w, logic [31:0] rdv, logic [31:0] exp_rd, logic exp_err,
                         int exp_strb, logic [3:0] exp_be, logic [31:0] exp_wd);
      exp_t e;
      logic st;
      st = (op inside {OP_SB, OP_SH, OP_SW});
      wait_ready();
      waits    = w;
      rd_val   = rdv;
      strb_n   = 0;
      saw_rd   = 1'b0;
      saw_wr   = 1'b0;
      both_hi  = 1'b0;
      unstable = 1'b0;
      e.rdata  = exp_rd;
      e.err    = exp_err;
      e.cyc    = cyc + 1 + exp_strb;
      sbq.push_back(e);
      drive_accept(op, a, wd);
      for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
      if (sbq.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: got no resp, required one within 40 cycles", nm);
         sbq.delete();
      end
      @(negedge clk);
      chk({nm, "_strobe_cycles"}, strb_n, exp_strb);
      if (exp_strb > 0) begin
         chk({nm, "_address"}, s_addr, {a[31:2], 2'b00});
         chk({nm, "_byteenable"}, {28'h0, s_be}, {28'h0, exp_be});
         chk({nm, "_kind"}, {30'h0, saw_wr, saw_rd}, {30'h0, st, ~st});
         chk({nm, "_stable_excl"}, {30'h0, both_hi, unstable}, 32'h0);
         if (st) chk({nm, "_writedata"}, s_wd, exp_wd);
      end
   endtask

   initial begin
      req.req_valid = 1'b0;
      req.req_op    = OP_LB;
      req.req_addr  = '0;
      req.req_wdata = '0;
      strb_n = 0; saw_rd = 0; saw_wr = 0; both_hi = 0; unstable = 0;
      s_addr = '0; s_be = '0; s_wd = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'h0, req.req_ready}, 32'h1);
      chk("rst_outs", {28'h0, req.resp_valid, req.resp_error, avm.avm_read, avm.avm_write}, 32'h0);
      chk("rst_bus", avm.avm_address | avm.avm_writedata | {28'h0, avm.avm_byteenable}, 32'h0);
      chk("rst_rdata", req.resp_rdata, 32'h0);
      rst_n = 1'b1;

      // Reset while the slave stalls a word load.
      wait_ready();
      waits = 1000;
      drive_accept(OP_LW, 32'hBFC0_0000, 32'h0);
      @(negedge clk);
      chk("midbus_read_hi", {31'h0, avm.avm_read}, 32'h1);
      chk("midbus_addr", avm.avm_address, 32'hBFC0_0000);
      #2 rst_n = 1'b0;
      #1;
      chk("midbus_read_drop", {30'h0, avm.avm_read, avm.avm_write}, 32'h0);
      chk("midbus_ready", {31'h0, req.req_ready}, 32'h1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      do_req("sb", OP_SB, 32'h0000_0102, 32'h0000_00A5, 0, 32'hDEAD_BEEF,
             32'h0, 1'b0, 1, 4'b0100, 32'hA5A5_A5A5);
      do_req("lb", OP_LB, 32'h0000_0103, 32'h0, 3, 32'h8012_3456,
             32'hFFFF_FF80, 1'b0, 4, 4'b1000, 32'h0);
      do_req("lbu", OP_LBU, 32'h0000_0103, 32'h0, 3, 32'h8012_3456,
             32'h0000_0080, 1'b0, 4, 4'b1000, 32'h0);
      do_req("lh", OP_LH, 32'h0000_0002, 32'h0, 0, 32'h9ABC_1234,
             32'hFFFF_9ABC, 1'b0, 1, 4'b1100, 32'h0);
      do_req("lhu", OP_LHU, 32'h0000_0002, 32'h0, 1, 32'h9ABC_1234,
             32'h0000_9ABC, 1'b0, 2, 4'b1100, 32'h0);
      do_req("lh_lo", OP_LH, 32'h0000_0010, 32'h0, 0, 32'h1234_8001,
             32'hFFFF_8001, 1'b0, 1, 4'b0011, 32'h0);
      do_req("sh", OP_SH, 32'h0000_0202, 32'h1234_BEEF, 2, 32'h0,
             32'h0, 1'b0, 3, 4'b1100, 32'hBEEF_BEEF);
      do_req("sw_mis", OP_SW, 32'h0000_0006, 32'h1111_2222, 0, 32'h0,
             32'h0, 1'b1, 0, 4'b0000, 32'h0);
      do_req("lh_mis", OP_LH, 32'h0000_0001, 32'h0, 0, 32'hFFFF_FFFF,
             32'h0, 1'b1, 0, 4'b0000, 32'h0);
      do_req("lw_tmo", OP_LW, 32'h0000_0040, 32'h0, 1000, 32'h7777_7777,
             32'h0, 1'b1, 4, 4'b1111, 32'h0);
      do_req("lw_after", OP_LW, 32'h0000_0044, 32'h0, 0, 32'h1234_5678,
             32'h1234_5678, 1'b0, 1, 4'b1111, 32'h0);
      do_req("sw", OP_SW, 32'h0000_0048, 32'hCAFE_F00D, 1, 32'h0,
             32'h0, 1'b0, 2, 4'b1111, 32'hCAFE_F00D);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mips_cpu_mem_access_unit.md
Name: mips_cpu_mem_access_unit

Overview:
- Avalon-MM master bridging the CPU load/store stage to the shared memory bus.
- Accepts one byte, halfword or word request at a time.
- Computes the word-aligned address, byteenable and lane-replicated writedata, then holds the transaction until waitrequest drops.
- Returns sign- or zero-extended load data; misaligned accesses and bus timeouts are reported as errors.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles in BUS before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned or timeout, qualified by resp_valid
- avm_address  out  32  word-aligned address {addr[31:2],2'b00}
- avm_byteenable  out  4  active byte lanes
- avm_read  out  1  read strobe
- avm_write  out  1  write strobe
- avm_writedata  out  32  lane-replicated store data
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data, valid when read=1 and waitrequest=0

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0 except req_ready=1.
  - avm_read and avm_write drop immediately, even mid-transaction.
  - No response is issued for the aborted request.
- Byte order is little-endian: lane k = bits [8k+7:8k], lane index = addr[1:0].
- Alignment rules:
  - Halfword ops need addr[0]=0.
  - Word ops need addr[1:0]=0.
  - Byte ops are always aligned.
- Byteenable:
  - Byte ops: 1<<addr[1:0].
  - Halfword ops: 0011 if addr[1]=0, 1100 if addr[1]=1.
  - Word ops: 1111.
- Writedata: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- Load extraction from the captured readdata lane:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- FSM, all outputs registered:
  - IDLE: req_ready=1. On req_valid, latch op and addr[1:0].
    - Aligned: drive avm_* from the next edge, clear the timeout counter, go to BUS.
    - Misaligned: go to DONE with error=1, no bus cycle.
  - BUS: avm_address, avm_byteenable, avm_writedata and read/write are held stable.
    - Clock edge with avm_waitrequest=0: deassert read/write; on a read capture avm_readdata; go to DONE with error=0.
    - Otherwise increment the counter. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1: deassert the strobe, go to DONE with error=1.
  - DONE: resp_valid=1 for exactly one cycle with resp_rdata and resp_error; req_ready=0; go to IDLE.
- Latency:
  - Request accepted at edge N; avm strobe high during cycle N+1.
  - If waitrequest is low in that cycle, resp_valid is high in cycle N+2.
  - Each wait cycle adds 1. Misaligned requests: resp_valid in cycle N+1.
- Throughput: at most one request per 3 cycles; req_valid while req_ready=0 is ignored (not queued).
- avm_read and avm_write are never high together; both are 0 outside BUS.
- req_op, req_addr and req_wdata are sampled only at acceptance; later changes have no effect.

Decomposition:
- Package mips_cpu_mem_pkg:
  - mem_op_t enum (the 8 encodings) and state_t enum (IDLE, BUS, DONE).
  - Functions is_store, is_aligned, byteenable_for.
- Sub-module mips_cpu_load_extract (combinational): inputs op, offset, readdata; output resp_rdata.

Test Plan:
- Reset mid-BUS: issue LW 0xBFC00000, pull reset_n low while waitrequest=1 -> avm_read=0 immediately, req_ready=1, resp_valid never pulses.
- SB to 0x00000102 with wdata 0x000000A5, waitrequest=0 -> byteenable 0100, writedata 0xA5A5A5A5, address 0x00000100, resp_valid 2 cycles after acceptance, error=0.
- LB at 0x00000103 with readdata 0x80123456 held for 3 wait cycles -> read held stable 4 cycles, resp_rdata 0xFFFFFF80; the same access as LBU -> 0x00000080.
- LH at 0x00000002 with readdata 0x9ABC1234 -> byteenable 1100, resp_rdata 0xFFFF9ABC; LHU -> 0x00009ABC.
- SW to 0x00000006 -> no avm strobe, resp_valid next cycle, resp_error=1, resp_rdata 0.
- TIMEOUT_CYCLES=4, LW with waitrequest stuck at 1 -> read high exactly 4 cycles, then resp_error=1; the next request is accepted normally.
